// File: rtl/ls_ex_queue_pkg.sv
// ls_ex_queue shared types: opcodes, FSM states, mc flags and size codes.
package ls_ex_queue_pkg;

  localparam int OPW = 6;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 6'd0,
    OP_LB  = 6'd1,
    OP_LH  = 6'd2,
    OP_LW  = 6'd3,
    OP_LBU = 6'd4,
    OP_LHU = 6'd5,
    OP_SB  = 6'd6,
    OP_SH  = 6'd7,
    OP_SW  = 6'd8
  } openum_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } ls_state_e;

  localparam logic FLAG_READ  = 1'b0;
  localparam logic FLAG_WRITE = 1'b1;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  function automatic logic is_load(input openum_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic [2:0] op_size(input openum_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input openum_e op,
                                      input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ls_ex_fifo.sv
// ls_ex_fifo: in-order circular buffer of memory ops with per-entry kill bits.
module ls_ex_fifo
  import ls_ex_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_kill_loads,
  input  openum_e           i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_full,
  output logic              o_empty,
  output openum_e           o_op,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_kill
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  openum_e           r_op   [QDEPTH];
  logic [ADDR_W-1:0] r_addr [QDEPTH];
  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [TAG_W-1:0]  r_tag  [QDEPTH];
  logic [QDEPTH-1:0] r_kill;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;

  assign o_full  = (r_cnt == CW'(QDEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_op    = r_op[r_rptr];
  assign o_addr  = r_addr[r_rptr];
  assign o_data  = r_data[r_rptr];
  assign o_tag   = r_tag[r_rptr];
  assign o_kill  = r_kill[r_rptr];

  always_ff @(posedge clk) begin
    if (i_rdy && i_push) begin
      r_op[r_wptr]   <= i_op;
      r_addr[r_wptr] <= i_addr;
      r_data[r_wptr] <= i_data;
      r_tag[r_wptr]  <= i_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_kill <= '0;
    end else if (i_rdy) begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      for (int i = 0; i < QDEPTH; i++) begin
        if (i_kill_loads && is_load(r_op[i])) r_kill[i] <= 1'b1;
      end
      // The write slot is free, so a fresh entry always starts live.
      if (i_push) r_kill[r_wptr] <= 1'b0;
    end
  end

endmodule

// File: rtl/ls_ex_queue.sv
// ls_ex_queue: in-order load/store issue to mc with tagged CDB results.
// Optional LS_EX_MISALIGN_CHECK_EN pops misaligned heads as faults.
module ls_ex_queue
  import ls_ex_queue_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int QDEPTH   = 4,
  parameter int OPENUM_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena,
  input  logic [OPENUM_W-1:0] openum,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   store_value,
  input  logic [TAG_W-1:0]    rob_tag,
  output logic                busy_to_lsb,
  output logic                ena_to_mc,
  output logic [ADDR_W-1:0]   addr_to_mc,
  output logic [DATA_W-1:0]   data_to_mc,
  output logic                wr_flag_to_mc,
  output logic [2:0]          size_to_mc,
  input  logic                ok_flag_from_mc,
  input  logic [DATA_W-1:0]   data_from_mc,
  output logic                valid,
  output logic [DATA_W-1:0]   result,
  output logic [TAG_W-1:0]    result_tag,
  output logic                misalign_fault,
  input  logic                commit_jump_flag_from_rob
);

  openum_e           w_op;
  openum_e           w_hop;
  openum_e           r_op;
  ls_state_e         r_state;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic              w_hkill;
  logic              w_dead;
  logic              w_push;
  logic              w_pop;
  logic              w_mis;
  logic              r_fault;
  logic [ADDR_W-1:0] w_haddr;
  logic [DATA_W-1:0] w_hdata;
  logic [DATA_W-1:0] w_ext;
  logic [TAG_W-1:0]  w_htag;
  logic [TAG_W-1:0]  r_tag;

  assign w_op        = openum_e'(openum[OPW-1:0]);
  assign w_flush     = commit_jump_flag_from_rob;
  assign busy_to_lsb = w_full;
  assign w_push      = ena && (w_op != OP_NOP) && !w_full
                    && !(w_flush && is_load(w_op));
  assign w_pop       = rdy && (r_state == S_IDLE) && !w_empty;
  // A load reaching the head on a flush cycle is dead too.
  assign w_dead      = w_hkill || (w_flush && is_load(w_hop));
  assign misalign_fault = r_fault;

`ifdef LS_EX_MISALIGN_CHECK_EN
  assign w_mis = misaligned(w_hop, w_haddr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  ls_ex_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_rdy        (rdy),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_kill_loads (w_flush),
    .i_op         (w_op),
    .i_addr       (mem_addr),
    .i_data       (store_value),
    .i_tag        (rob_tag),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_op         (w_hop),
    .o_addr       (w_haddr),
    .o_data       (w_hdata),
    .o_tag        (w_htag),
    .o_kill       (w_hkill)
  );

  always_comb begin
    w_ext = data_from_mc;
    unique case (1'b1)
      (r_op == OP_LB):
        w_ext = {{(DATA_W-8){data_from_mc[7]}}, data_from_mc[7:0]};
      (r_op == OP_LH):
        w_ext = {{(DATA_W-16){data_from_mc[15]}}, data_from_mc[15:0]};
      (r_op == OP_LBU):
        w_ext = {{(DATA_W-8){1'b0}}, data_from_mc[7:0]};
      (r_op == OP_LHU):
        w_ext = {{(DATA_W-16){1'b0}}, data_from_mc[15:0]};
      default: w_ext = data_from_mc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_NOP;
      r_tag         <= '0;
      r_fault       <= 1'b0;
      ena_to_mc     <= 1'b0;
      addr_to_mc    <= '0;
      data_to_mc    <= '0;
      wr_flag_to_mc <= FLAG_READ;
      size_to_mc    <= '0;
      valid         <= 1'b0;
      result        <= '0;
      result_tag    <= '0;
    end else if (rdy) begin
      ena_to_mc <= 1'b0;
      valid     <= 1'b0;
      r_fault   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !w_dead) begin
            if (w_mis) begin
              r_fault <= 1'b1;
              if (is_load(w_hop)) begin
                valid      <= 1'b1;
                result     <= '0;
                result_tag <= w_htag;
              end
            end else begin
              ena_to_mc     <= 1'b1;
              addr_to_mc    <= w_haddr;
              data_to_mc    <= w_hdata;
              wr_flag_to_mc <= is_load(w_hop) ? FLAG_READ : FLAG_WRITE;
              size_to_mc    <= op_size(w_hop);
              r_op          <= w_hop;
              r_tag         <= w_htag;
              r_state       <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (ok_flag_from_mc) begin
            r_state <= S_IDLE;
            if (is_load(r_op) && !w_flush) begin
              valid      <= 1'b1;
              result     <= w_ext;
              result_tag <= r_tag;
            end
          end else if (w_flush && is_load(r_op)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ok_flag_from_mc) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
